exponential: RTL and testbench

EXPONENTIAL -- requirements
Module: exponential

---
 rtl/exponential.sv | 157 +++++++++++++++
 tb/tb_exponential.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/exponential.sv
// -----------------------------------------------------------------------------
// exponential -- sequential e^x evaluator for x in [0,1)
//
// Evaluates e^x as a degree-8 Taylor polynomial in Horner form, one multiply-add
// step per clock:
//     acc = c8
//     for k = 7 down to 0: acc = trunc(acc * x) + c_k
// where c_k = 1/k! in unsigned 2.16 fixed point.
//
// Ports
//     clk       in   1   system clock, rising-edge active
//     rst       in   1   synchronous, active-high reset
//     start     in   1   level request; sampled only in IDLE
//     x         in  16   operand, unsigned 0.16 (value = x / 65536)
//     done      out  1   one-cycle pulse, result valid
//     intpart   out  2   integer part of e^x (1 or 2)
//     fracpart  out 16   fractional part of e^x, 0.16
//
// Configuration
//     EXP_ROUND_EN  defined: each Horner step adds 0x8000 to the product
//                   before dropping the low 16 bits (round-half-up).
//                   undefined: plain truncation. Timing and ports unchanged.
//
// Timing: start sampled in IDLE on edge E0 -> eight CALC steps on E1..E8 ->
// done high during the cycle after E8 (9th cycle after E0).
// -----------------------------------------------------------------------------
module exponential (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x,
    output logic        done,
    output logic [1:0]  intpart,
    output logic [15:0] fracpart
);

    // state | meaning
    // IDLE  | waiting for start; operand latched on the accepting edge
    // CALC  | one Horner step per cycle, k = 7 .. 0
    // DONE  | done pulse high for this single cycle
    // WAIT  | result delivered; hold here until start is released
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam logic [17:0] C0 = 18'h10000;
    localparam logic [17:0] C1 = 18'h10000;
    localparam logic [17:0] C2 = 18'h08000;
    localparam logic [17:0] C3 = 18'h02AAB;
    localparam logic [17:0] C4 = 18'h00AAB;
    localparam logic [17:0] C5 = 18'h00222;
    localparam logic [17:0] C6 = 18'h0005B;
    localparam logic [17:0] C7 = 18'h0000D;
    localparam logic [17:0] C8 = 18'h00002;

    state_t      r_state;
    logic [17:0] r_acc;
    logic [2:0]  r_k;
    logic [15:0] r_x;
    logic        r_done;
    logic [1:0]  r_intpart;
    logic [15:0] r_fracpart;

    logic [17:0] w_coef;
    logic [33:0] w_prod;
    logic [33:0] w_prod_adj;
    logic [17:0] w_trunc;
    logic [17:0] w_next;

    // Coefficient added in the step indexed by r_k (c8 only seeds the accumulator)
    always_comb begin
        w_coef = C0;
        case (r_k)
            3'd0: w_coef = C0;
            3'd1: w_coef = C1;
            3'd2: w_coef = C2;
            3'd3: w_coef = C3;
            3'd4: w_coef = C4;
            3'd5: w_coef = C5;
            3'd6: w_coef = C6;
            3'd7: w_coef = C7;
            default: w_coef = C0;
        endcase
    end

    // 2.16 x 0.16 -> 2.32 product; keeping bits [33:16] returns to 2.16.
    // acc stays below e (< 0x2B7E2), so the product and the rounding add
    // both fit in 34 bits, and acc*x + c_k fits in 18 bits for x < 1.
    assign w_prod = {16'd0, r_acc} * {18'd0, r_x};

`ifdef EXP_ROUND_EN
    assign w_prod_adj = w_prod + 34'h0_0000_8000;
`else
    assign w_prod_adj = w_prod;
`endif

    assign w_trunc = 18'(w_prod_adj >> 16);
    assign w_next  = w_trunc + w_coef;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_k        <= '0;
            r_x        <= '0;
            r_done     <= 1'b0;
            r_intpart  <= '0;
            r_fracpart <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x     <= x;
                        r_acc   <= C8;
                        r_k     <= 3'd7;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= w_next;
                    if (r_k == 3'd0) begin
                        // Final step: publish result and raise done together
                        r_intpart  <= w_next[17:16];
                        r_fracpart <= w_next[15:0];
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_k <= r_k - 3'd1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_done <= 1'b0;
                    if (!start) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign done     = r_done;
    assign intpart  = r_intpart;
    assign fracpart = r_fracpart;

endmodule

// File: tb/tb_exponential.sv
module tb_exponential;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic        done;
    logic [1:0]  intpart;
    logic [15:0] fracpart;

    exponential dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x        (x),
        .done     (done),
        .intpart  (intpart),
        .fracpart (fracpart)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] xv;
        logic [17:0] res;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    // Reference: Taylor coefficients 1/k! in 2.16, Horner evaluation with
    // plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] xv);
        longint c [9] = '{65536, 65536, 32768, 10923, 2731, 546, 91, 13, 2};
        longint acc;
        longint p;
        acc = c[8];
        for (int k = 7; k >= 0; k--) begin
            p = acc * longint'(xv);
`ifdef EXP_ROUND_EN
            p = p + 32768;
`endif
            acc = (p >>> 16) + c[k];
        end
        return 18'(acc);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_near(input string name, input logic [15:0] xv,
                              input int int_req, input int frac_req);
        int d;
        n_tests++;
        d = int'(fracpart) - frac_req;
        if (d < 0) d = -d;
        if (int'(intpart) != int_req || d > 8) begin
            n_fail++;
            $display("FAIL %s x=0x%h actual=%0d.0x%h required=%0d.0x%h(+-8)",
                     name, xv, intpart, fracpart, int_req, frac_req);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        exp_t e;
        real  ref_v;
        real  got_v;
        if (done) begin
            n_done++;
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done actual=%0d.0x%h required=no_pulse",
                         intpart, fracpart);
            end else begin
                e = sbq.pop_front();
                if ({intpart, fracpart} !== e.res) begin
                    n_fail++;
                    $display("FAIL result x=0x%h actual=0x%h required=0x%h",
                             e.xv, {intpart, fracpart}, e.res);
                end
                ref_v = $exp(real'(e.xv) / 65536.0) * 65536.0;
                got_v = real'({intpart, fracpart});
                n_tests++;
                if (got_v - ref_v > 8.0 || ref_v - got_v > 8.0) begin
                    n_fail++;
                    $display("FAIL accuracy x=0x%h actual=0x%h required=%f(+-8)",
                             e.xv, {intpart, fracpart}, ref_v);
                end
            end
        end
    end

    // Entered #1 after a posedge with the DUT idle; leaves it idle again.
    task automatic run_one(input logic [15:0] xv, input bit scramble);
        exp_t e;
        int   lat;
        x     = xv;
        start = 1'b1;
        e.xv  = xv;
        e.res = model(xv);
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 30) begin
            if (scramble) x = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("held_result", {intpart, fracpart}, e.res);
    endtask

    initial begin
        int   d0;
        logic [15:0] xr;

        rst   = 1'b1;
        start = 1'b0;
        x     = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", done, 0);
        check("reset_out", {intpart, fracpart}, 0);

        // Start on the very first edge after reset release
        rst = 1'b0;
        run_one(16'h0000, 1'b0);
        check("x0_exact", {intpart, fracpart}, 18'h10000);

        run_one(16'h8000, 1'b0);
        check_near("x_half", 16'h8000, 1, 16'hA612);
        run_one(16'h4000, 1'b0);
        check_near("x_quarter", 16'h4000, 1, 16'h48B6);
        run_one(16'hFFFF, 1'b0);
        check_near("x_max", 16'hFFFF, 2, 16'hB7DD);

        // start held high: exactly one result
        d0    = n_done;
        x     = 16'h1234;
        start = 1'b1;
        begin
            exp_t e;
            e.xv  = 16'h1234;
            e.res = model(16'h1234);
            sbq.push_back(e);
        end
        repeat (20) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("held_start_pulses", n_done - d0, 1);
        run_one(16'hC000, 1'b0);

        // Reset mid-computation: outputs clear, no pulse, then recover
        x     = 16'h7777;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midcalc_rst_done", done, 0);
        check("midcalc_rst_out", {intpart, fracpart}, 0);
        rst = 1'b0;
        d0  = n_done;
        repeat (15) begin
            @(posedge clk); #1;
        end
        check("aborted_no_pulse", n_done - d0, 0);
        run_one(16'h7777, 1'b0);

        // Operand changes during CALC must not matter
        run_one(16'h2468, 1'b1);

        // Randomized operands, with and without operand disturbance
        for (int i = 0; i < 30; i++) begin
            xr = 16'($urandom);
            run_one(xr, ($urandom % 2) == 1);
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("scoreboard_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
